// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall controller: state encoding,
// register constants and default MDU latencies.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_e;

  localparam logic [4:0]  REG_ZERO     = 5'd0;
  localparam int unsigned MULT_LAT_DEF = 4;
  localparam int unsigned DIV_LAT_DEF  = 32;
  localparam int unsigned MDU_CNT_W    = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: load-use and MDU stalls,
// branch flushes, MDU latency tracking and saturating stall/flush counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_reads_hilo,
  input  logic             id_is_mdu,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_start,
  input  logic             ex_mdu_is_div,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [MDU_CNT_W-1:0] MULT_LOAD = MDU_CNT_W'(MULT_LAT - 1);
  localparam logic [MDU_CNT_W-1:0] DIV_LOAD  = MDU_CNT_W'(DIV_LAT - 1);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [MDU_CNT_W-1:0]   r_mdu_cnt;
  logic [MDU_CNT_W-1:0]   w_mdu_cnt_nxt;
  logic [MDU_CNT_W-1:0]   w_mdu_load;
  logic                   w_mdu_done;
  logic                   w_mdu_busy;
  logic                   w_load_use;
  logic                   w_mdu_stall;
  logic                   w_stall;

  assign w_mdu_load = ex_mdu_is_div ? DIV_LOAD : MULT_LOAD;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= RUN;
      r_mdu_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mdu_cnt <= w_mdu_cnt_nxt;
    end
  end

  // A new issue always wins over completion, so back-to-back ops never pulse done.
  always_comb begin
    w_state_nxt   = r_state;
    w_mdu_cnt_nxt = r_mdu_cnt;
    w_mdu_done    = 1'b0;
    case (r_state)
      RUN: begin
        if (ex_mdu_start) begin
          w_state_nxt   = MDU_WAIT;
          w_mdu_cnt_nxt = w_mdu_load;
        end
      end
      MDU_WAIT: begin
        if (ex_mdu_start) begin
          w_mdu_cnt_nxt = w_mdu_load;
        end else if (r_mdu_cnt == '0) begin
          w_state_nxt = RUN;
          w_mdu_done  = 1'b1;
        end else begin
          w_mdu_cnt_nxt = r_mdu_cnt - MDU_CNT_W'(1);
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign w_mdu_busy  = (r_state == MDU_WAIT) && !w_mdu_done;
  assign w_load_use  = ex_mem_read && (ex_rd != REG_ZERO) &&
                       ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
  assign w_mdu_stall = w_mdu_busy && (id_reads_hilo || id_is_mdu);
  assign w_stall     = w_load_use || w_mdu_stall;

  // Branch squashes the ID instruction, so it overrides any stall.
  assign pc_hold     = rst && !ex_branch_taken && w_stall;
  assign ifid_hold   = rst && !ex_branch_taken && w_stall;
  assign ifid_flush  = rst && ex_branch_taken;
  assign idex_bubble = rst && (ex_branch_taken || w_stall);
  assign mdu_busy    = rst && w_mdu_busy;
  assign mdu_done    = rst && w_mdu_done;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (pc_hold),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .en  (ifid_flush),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a second 4-bit-counter instance covers saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_use_rs, id_use_rt, id_reads_hilo, id_is_mdu;
  logic        ex_mem_read, ex_branch_taken, ex_mdu_start, ex_mdu_is_div;
  logic        pc_hold, ifid_hold, ifid_flush, idex_bubble, mdu_busy, mdu_done;
  logic [31:0] stall_cnt, flush_cnt;
  logic        pc_hold4, ifid_hold4, ifid_flush4, idex_bubble4, mdu_busy4, mdu_done4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_reads_hilo(id_reads_hilo), .id_is_mdu(id_is_mdu),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .ex_mdu_start(ex_mdu_start), .ex_mdu_is_div(ex_mdu_is_div),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .mdu_busy(mdu_busy), .mdu_done(mdu_done),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_reads_hilo(id_reads_hilo), .id_is_mdu(id_is_mdu),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .ex_mdu_start(ex_mdu_start), .ex_mdu_is_div(ex_mdu_is_div),
    .pc_hold(pc_hold4), .ifid_hold(ifid_hold4), .ifid_flush(ifid_flush4),
    .idex_bubble(idex_bubble4), .mdu_busy(mdu_busy4), .mdu_done(mdu_done4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_reads_hilo = 1'b0; id_is_mdu = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_mdu_start = 1'b0; ex_mdu_is_div = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
  endtask

  task automatic load_use_r8();
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
  endtask

  initial begin
    // Reset holds everything low even with a flush and a load-use applied.
    idle();
    rst = 1'b0;
    ex_branch_taken = 1'b1;
    load_use_r8();
    #3;
    chk("rst_pc_hold", pc_hold, 0);
    chk("rst_ifid_hold", ifid_hold, 0);
    chk("rst_ifid_flush", ifid_flush, 0);
    chk("rst_idex_bubble", idex_bubble, 0);
    chk("rst_mdu_busy", mdu_busy, 0);
    chk("rst_mdu_done", mdu_done, 0);
    tick(); tick();
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    rst = 1'b1;
    #1;
    chk("rel_ifid_flush", ifid_flush, 1);
    chk("rel_idex_bubble", idex_bubble, 1);
    chk("rel_pc_hold", pc_hold, 0);
    chk("rel_ifid_hold", ifid_hold, 0);
    tick();
    chk("rel_flush_cnt", flush_cnt, 1);
    chk("rel_stall_cnt", stall_cnt, 0);

    // Load-use on rs, then the rd=0 and no-use cases, then an rt match.
    do_reset();
    load_use_r8();
    #1;
    chk("lu_pc_hold", pc_hold, 1);
    chk("lu_ifid_hold", ifid_hold, 1);
    chk("lu_idex_bubble", idex_bubble, 1);
    chk("lu_ifid_flush", ifid_flush, 0);
    tick();
    idle();
    #1;
    chk("lu_release", pc_hold, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    load_use_r8(); ex_rd = 5'd0; id_rs = 5'd0;
    #1;
    chk("lu_rd0", pc_hold, 0);
    load_use_r8(); id_use_rs = 1'b0;
    #1;
    chk("lu_no_use", idex_bubble, 0);
    load_use_r8(); id_rs = 5'd3; id_use_rs = 1'b1; id_rt = 5'd8; id_use_rt = 1'b1;
    #1;
    chk("lu_rt", ifid_hold, 1);
    tick();
    idle();
    chk("lu_stall_cnt2", stall_cnt, 2);

    // Branch wins over a simultaneous load-use.
    do_reset();
    load_use_r8();
    ex_branch_taken = 1'b1;
    #1;
    chk("br_ifid_flush", ifid_flush, 1);
    chk("br_idex_bubble", idex_bubble, 1);
    chk("br_pc_hold", pc_hold, 0);
    chk("br_ifid_hold", ifid_hold, 0);
    tick();
    idle();
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 0);

    // Divide with a dependent mfhi held in ID.
    do_reset();
    ex_mdu_start = 1'b1; ex_mdu_is_div = 1'b1; id_reads_hilo = 1'b1;
    #1;
    chk("div_c0_busy", mdu_busy, 0);
    chk("div_c0_pc_hold", pc_hold, 0);
    tick();
    ex_mdu_start = 1'b0; ex_mdu_is_div = 1'b0;
    for (int c = 1; c <= 31; c++) begin
      #1;
      chk("div_busy", mdu_busy, 1);
      chk("div_pc_hold", pc_hold, 1);
      chk("div_done_early", mdu_done, 0);
      tick();
    end
    #1;
    chk("div_c32_done", mdu_done, 1);
    chk("div_c32_busy", mdu_busy, 0);
    chk("div_c32_pc_hold", pc_hold, 0);
    tick();
    idle();
    chk("div_stall_cnt", stall_cnt, 31);

    // Multiply back-to-back, with an MDU stall and a branch while waiting.
    do_reset();
    ex_mdu_start = 1'b1;
    #1;
    chk("mul_c0_busy", mdu_busy, 0);
    tick();
    ex_mdu_start = 1'b0; id_is_mdu = 1'b1;
    #1;
    chk("mul_c1_busy", mdu_busy, 1);
    chk("mul_c1_pc_hold", pc_hold, 1);
    tick();
    id_is_mdu = 1'b0; ex_branch_taken = 1'b1;
    #1;
    chk("mul_c2_flush", ifid_flush, 1);
    chk("mul_c2_busy", mdu_busy, 1);
    tick();
    ex_branch_taken = 1'b0;
    #1;
    chk("mul_c3_busy", mdu_busy, 1);
    chk("mul_c3_done", mdu_done, 0);
    tick();
    #1;
    chk("mul_c4_done", mdu_done, 1);
    chk("mul_c4_busy", mdu_busy, 0);
    ex_mdu_start = 1'b1;
    #1;
    chk("mul_c4_done_supp", mdu_done, 0);
    chk("mul_c4_busy_reissue", mdu_busy, 1);
    tick();
    ex_mdu_start = 1'b0;
    for (int c = 5; c <= 7; c++) begin
      #1;
      chk("mul2_busy", mdu_busy, 1);
      chk("mul2_done_early", mdu_done, 0);
      tick();
    end
    #1;
    chk("mul_c8_done", mdu_done, 1);
    tick();
    #1;
    chk("mul_c9_busy", mdu_busy, 0);
    chk("mul_c9_done", mdu_done, 0);

    // Reset in the middle of the second multiply.
    do_reset();
    ex_mdu_start = 1'b1;
    tick();
    ex_mdu_start = 1'b0;
    tick(); tick(); tick();
    ex_mdu_start = 1'b1;
    tick();
    ex_mdu_start = 1'b0;
    tick();
    #1;
    chk("mrst_c6_busy_pre", mdu_busy, 1);
    rst = 1'b0;
    #1;
    chk("mrst_busy_now", mdu_busy, 0);
    tick();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("mrst_no_done", mdu_done, 0);
      chk("mrst_no_busy", mdu_busy, 0);
      tick();
    end

    // Saturation of the 4-bit counter build under a held stall.
    do_reset();
    load_use_r8();
    repeat (14) tick();
    chk("sat_cnt4_14", stall_cnt4, 4'hE);
    chk("sat_cnt32_14", stall_cnt, 14);
    repeat (6) tick();
    chk("sat_cnt4_20", stall_cnt4, 4'hF);
    chk("sat_cnt32_20", stall_cnt, 20);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
